// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings
// and the sizing rule for the bit index counter.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit operand still needs a one-bit index register.
  function automatic int idx_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder made from two half adders whose carries are ORed.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic h1_sum;
  logic h1_carry;
  logic h2_carry;

  assign h1_sum   = a ^ b;
  assign h1_carry = a & b;
  assign sum      = h1_sum ^ cin;
  assign h2_carry = h1_sum & cin;
  assign cout     = h1_carry | h2_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder evaluation per clock, LSB first,
// with the assembled result published to sum/cout for a single DONE cycle.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int             IW   = idx_width(WIDTH);
  localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial result with the current bit inserted; also the final result on the
  // last RUN edge, so sum can be loaded in the same edge that enters DONE.
  always_comb begin
    acc_next      = acc;
    acc_next[idx] = fa_sum;
  end

  // NOTE: every register, operand latches included, sits on the async reset so
  // an aborted operation leaves no stale partial state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of idx, carry and acc.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= fa_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            sum   <= acc_next;
            cout  <= fa_cout;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 1-bit instance for the degenerate width.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] sum;
  logic       cout, busy, done;

  logic start1 = 1'b0, sub1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic sum1, cout1, busy1, done1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
  );

  // Runs one operation on the 8-bit DUT. Operands are scrambled while busy;
  // glitch_k > 0 additionally pulses start (a=AA) after that many RUN edges.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                       input int glitch_k, output int lat, output int busy_n,
                       output int done_n, output logic [7:0] rs, output logic rc,
                       output logic stable);
    logic [7:0] prev;
    @(posedge clk); #1;
    prev = sum; a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb_v; sub = ~ts;
    lat = 0; done_n = 0; stable = 1'b1; rs = sum; rc = cout;
    busy_n = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == glitch_k) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) begin lat = k; rs = sum; rc = cout; end
      end else if (lat == 0 && sum !== prev) begin
        stable = 1'b0;
      end
      if (!busy) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({sum, cout, busy, done} !== 11'd0) begin
      fails++; $display("FAIL reset_state: got sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
    tests++;
    if ({sum1, cout1, busy1, done1} !== 4'd0) begin
      fails++; $display("FAIL reset_state_w1: got %b%b%b%b, want 0000", sum1, cout1, busy1, done1);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, busy_n, done_n; logic [7:0] rs; logic rc, stable;
    do_op(8'h5A, 8'h33, 1'b0, 0, lat, busy_n, done_n, rs, rc, stable);
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL basic_latency: got %0d, want 8", lat); end
    tests++;
    if (busy_n !== 9) begin fails++; $display("FAIL basic_busy_cycles: got %0d, want 9", busy_n); end
    tests++;
    if (done_n !== 1) begin fails++; $display("FAIL basic_done_pulses: got %0d, want 1", done_n); end
    tests++;
    if ({rs, rc} !== {8'h8D, 1'b0}) begin fails++; $display("FAIL basic_result: got %h/%b, want 8d/0", rs, rc); end
    tests++;
    if (!stable) begin fails++; $display("FAIL basic_sum_stable: sum moved during RUN, want held"); end
  endtask

  task automatic test_arith();
    logic [7:0] ta [5] = '{8'hFF, 8'h10, 8'h00, 8'h33, 8'h80};
    logic [7:0] tv [5] = '{8'h01, 8'h01, 8'h01, 8'h33, 8'h80};
    logic       tsb[5] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
    logic [7:0] es [5] = '{8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00};
    logic       ec [5] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    int lat, busy_n, done_n; logic [7:0] rs; logic rc, stable;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tv[i], tsb[i], 0, lat, busy_n, done_n, rs, rc, stable);
      tests++;
      if ({rs, rc} !== {es[i], ec[i]} || done_n !== 1 || lat !== 8) begin
        fails++;
        $display("FAIL arith_%0d: got %h/%b done=%0d lat=%0d, want %h/%b done=1 lat=8",
                 i, rs, rc, done_n, lat, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, busy_n, done_n; logic [7:0] rs; logic rc, stable;
    do_op(8'h12, 8'h34, 1'b0, 3, lat, busy_n, done_n, rs, rc, stable);
    tests++;
    if ({rs, rc} !== {8'h46, 1'b0}) begin fails++; $display("FAIL ignore_result: got %h/%b, want 46/0", rs, rc); end
    tests++;
    if (done_n !== 1) begin fails++; $display("FAIL ignore_done_pulses: got %0d, want 1", done_n); end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || sum !== 8'h46) begin
      fails++; $display("FAIL ignore_no_queue: got busy=%b sum=%h, want 0/46", busy, sum);
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n, done_n; logic [7:0] rs; logic rc, stable;
    int seen_done;
    @(posedge clk); #1;
    a = 8'hF0; b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      fails++; $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b, want 0/0/00/0", busy, done, sum, cout);
    end
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done) seen_done++;
    end
    tests++;
    if (seen_done !== 0) begin fails++; $display("FAIL midrun_no_done: got %0d pulses, want 0", seen_done); end
    do_op(8'h5A, 8'h33, 1'b0, 0, lat, busy_n, done_n, rs, rc, stable);
    tests++;
    if ({rs, rc} !== {8'h8D, 1'b0} || lat !== 8) begin
      fails++; $display("FAIL after_reset_op: got %h/%b lat=%0d, want 8d/0 lat=8", rs, rc, lat);
    end
  endtask

  task automatic test_back_to_back();
    int d_at[2]; logic [7:0] d_sum[2]; logic d_c[2]; int n;
    n = 0; d_at[0] = 0; d_at[1] = 0;
    d_sum[0] = '0; d_sum[1] = '0; d_c[0] = 1'b0; d_c[1] = 1'b0;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin a = 8'h10; b = 8'h03; sub = 1'b1; end
      if (done && n < 2) begin
        d_at[n] = k; d_sum[n] = sum; d_c[n] = cout; n++;
        if (n == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    tests++;
    if (n !== 2) begin fails++; $display("FAIL b2b_count: got %0d dones, want 2", n); end
    tests++;
    if (d_at[1] - d_at[0] !== 10) begin fails++; $display("FAIL b2b_period: got %0d, want 10", d_at[1] - d_at[0]); end
    tests++;
    if ({d_sum[0], d_c[0], d_sum[1], d_c[1]} !== {8'h03, 1'b0, 8'h0D, 1'b1}) begin
      fails++; $display("FAIL b2b_results: got %h/%b %h/%b, want 03/0 0d/1", d_sum[0], d_c[0], d_sum[1], d_c[1]);
    end
  endtask

  task automatic test_width1();
    logic [1:0] es = 2'b00;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      case (v)
        2'b00: es = 2'b00;
        2'b01: es = 2'b10;
        2'b10: es = 2'b10;
        default: es = 2'b01;
      endcase
      @(posedge clk); #1;
      a1 = v[1]; b1 = v[0]; sub1 = 1'b0; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      tests++;
      if (done1 !== 1'b0 || busy1 !== 1'b1) begin
        fails++; $display("FAIL w1_run_%0d: got done=%b busy=%b, want 0/1", i, done1, busy1);
      end
      @(posedge clk); #1;
      tests++;
      if (done1 !== 1'b1 || {sum1, cout1} !== es) begin
        fails++; $display("FAIL w1_result_%0d: got done=%b sum/cout=%b%b, want 1 %b", i, done1, sum1, cout1, es);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
